// File: rtl/alu_sequencer_if.sv
// Control bus between alu_sequencer and its program ROM / accumulator datapath.
// Latency: none, wires only.
// Backpressure: none; run pauses the sequencer in FETCH.
// Ports: master = sequencer side (drives pc/en/f/b/flags/halted; receives run/instr/carry/zero),
//        slave = ROM + datapath side (mirror image).
interface alu_sequencer_if #(
    parameter int PC_W = 4
);
    logic            run;
    logic [7:0]      instr;
    logic            carry;
    logic            zero;
    logic [PC_W-1:0] pc;
    logic [2:0]      en;
    logic [2:0]      f;
    logic [3:0]      b;
    logic            c_flag;
    logic            z_flag;
    logic            halted;

    modport master (
        input  run, instr, carry, zero,
        output pc, en, f, b, c_flag, z_flag, halted
    );

    modport slave (
        output run, instr, carry, zero,
        input  pc, en, f, b, c_flag, z_flag, halted
    );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode controller for the accumulator ALU datapath; fetches from a combinational ROM.
// Latency: two clocks per instruction (FETCH then EXEC); HALT is absorbing until reset.
// Backpressure: run=0 holds the sequencer in FETCH with idle outputs; run is ignored in EXEC and HALT.
// Ports: clk, reset (sync, active-high); bus (master modport): run, instr, carry, zero in;
//        pc, en, f, b, c_flag, z_flag, halted out.
module alu_sequencer #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    alu_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic [7:0]      instr_q, instr_nxt;
    logic            c_q, c_nxt;
    logic            z_q, z_nxt;

    logic [3:0]      opc;
    logic [3:0]      n;

    assign opc = instr_q[7:4];
    assign n   = instr_q[3:0];

    // State register: all architectural state lives here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            c_q     <= c_nxt;
            z_q     <= z_nxt;
        end
    end

    // Next-state logic: sequencing, pc update, flag capture.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        c_nxt     = c_q;
        z_nxt     = z_q;
        case (state)
            FETCH: begin
                if (bus.run) begin
                    instr_nxt = bus.instr;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = FETCH;
                pc_nxt    = pc_q + PC_W'(1);
                // Only ALU-using opcodes capture the live datapath flags.
                if (opc >= 4'h1 && opc <= 4'h5) begin
                    c_nxt = bus.carry;
                    z_nxt = bus.zero;
                end
                // Branches test the flags captured by an earlier instruction.
                case (opc)
                    4'h7: pc_nxt = PC_W'(n);
                    4'h8: if (c_q)  pc_nxt = PC_W'(n);
                    4'h9: if (!c_q) pc_nxt = PC_W'(n);
                    4'hA: if (z_q)  pc_nxt = PC_W'(n);
                    4'hB: if (!z_q) pc_nxt = PC_W'(n);
                    4'hF: begin
                        pc_nxt    = pc_q;
                        state_nxt = HALT;
                    end
                    default: ;
                endcase
            end
            HALT: ;
            default: state_nxt = FETCH;
        endcase
    end

    // Output decode: datapath controls are only non-idle during EXEC.
    always_comb begin
        bus.en = 3'b000;
        bus.f  = 3'b000;
        bus.b  = 4'h0;
        if (state == EXEC) begin
            case (opc)
                4'h1: begin bus.en = 3'b011; bus.f = 3'b010; bus.b = n; end
                4'h2: begin bus.en = 3'b011; bus.f = 3'b011; bus.b = n; end
                4'h3: begin bus.en = 3'b011; bus.f = 3'b001; bus.b = n; end
                4'h4: begin bus.en = 3'b011; bus.f = 3'b100; bus.b = n; end
                4'h5: begin bus.en = 3'b001; bus.f = 3'b001; bus.b = n; end
                4'h6: begin bus.en = 3'b100; end
                default: ;
            endcase
        end
    end

    assign bus.pc     = pc_q;
    assign bus.c_flag = c_q;
    assign bus.z_flag = z_q;
    assign bus.halted = (state == HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_sequencer_if #(.PC_W(4)) bus ();

    alu_sequencer #(.PC_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Program ROM and accumulator datapath model.
    logic [7:0] rom [16];
    logic [3:0] acc;
    logic [3:0] bsel;
    logic [4:0] r5;
    logic [3:0] y;
    logic       run_drv;

    assign bus.run   = run_drv;
    assign bus.instr = rom[bus.pc];

    always_comb begin
        bsel = bus.en[0] ? bus.b : 4'h0;
        case (bus.f)
            3'b001:  r5 = {1'b0, acc} - {1'b0, bsel};
            3'b010:  r5 = {1'b0, bsel};
            3'b011:  r5 = {1'b0, acc} + {1'b0, bsel};
            3'b100:  r5 = {1'b0, ~(acc & bsel)};
            default: r5 = {1'b0, acc};
        endcase
    end

    assign bus.carry = r5[4];
    assign bus.zero  = (r5[3:0] == 4'h0);
    assign y         = bus.en[2] ? acc : 4'h0;

    always_ff @(posedge clk) begin
        if (reset)          acc <= 4'h0;
        else if (bus.en[1]) acc <= r5[3:0];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        run_drv = 1'b1;
        clear_rom();

        // Carry/zero from LIT F; ADD 1, then JC taken.
        rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h89; rom[9] = 8'hF0;
        do_reset();
        chk("reset_pc", bus.pc, 0);
        chk("reset_en", bus.en, 0);
        step(4);
        chk("add_carry", bus.c_flag, 1);
        chk("add_zero", bus.z_flag, 1);
        step(2);
        chk("jc_taken_pc", bus.pc, 9);
        step(2);
        chk("halt_at_9", bus.halted, 1);

        // Reset from HALT with flags set clears everything.
        reset = 1'b1;
        step(2);
        chk("rst_pc", bus.pc, 0);
        chk("rst_en", bus.en, 0);
        chk("rst_f", bus.f, 0);
        chk("rst_b", bus.b, 0);
        chk("rst_c", bus.c_flag, 0);
        chk("rst_z", bus.z_flag, 0);
        chk("rst_halted", bus.halted, 0);
        reset = 1'b0;

        // LIT 5; ADD 3; OUT; HALT.
        clear_rom();
        rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h60; rom[3] = 8'hF0;
        do_reset();
        step(1);
        chk("lit_en", bus.en, 3'b011);
        chk("lit_f", bus.f, 3'b010);
        chk("lit_b", bus.b, 5);
        step(4);
        chk("out_en", bus.en, 3'b100);
        chk("out_y", y, 4'b1000);
        step(3);
        chk("p2_halted", bus.halted, 1);
        chk("p2_c", bus.c_flag, 0);
        chk("p2_z", bus.z_flag, 0);
        chk("p2_pc", bus.pc, 3);
        run_drv = 1'b0;
        step(2);
        run_drv = 1'b1;
        step(3);
        chk("halt_frozen_pc", bus.pc, 3);
        chk("halt_idle_en", bus.en, 0);
        chk("halt_stays", bus.halted, 1);

        // LIT 4; CMP 4; JNZ 0; OUT.
        clear_rom();
        rom[0] = 8'h14; rom[1] = 8'h54; rom[2] = 8'hB0; rom[3] = 8'h60; rom[4] = 8'hF0;
        do_reset();
        step(3);
        chk("cmp_en", bus.en, 3'b001);
        step(1);
        chk("cmp_z", bus.z_flag, 1);
        chk("cmp_c", bus.c_flag, 0);
        step(2);
        chk("jnz_not_taken", bus.pc, 3);
        step(1);
        chk("cmp_acc_kept", y, 4'b0100);
        step(1);
        chk("p4_pc", bus.pc, 4);

        // Pause in FETCH, then run=0 during EXEC must not abort.
        clear_rom();
        rom[0] = 8'h13; rom[1] = 8'h23; rom[2] = 8'hF0;
        do_reset();
        step(2);
        run_drv = 1'b0;
        step(3);
        chk("pause_pc_mid", bus.pc, 1);
        step(2);
        chk("pause_pc", bus.pc, 1);
        chk("pause_en", bus.en, 0);
        chk("pause_f", bus.f, 0);
        chk("pause_b", bus.b, 0);
        chk("pause_z", bus.z_flag, 0);
        run_drv = 1'b1;
        step(1);
        chk("resume_en", bus.en, 3'b011);
        chk("resume_b", bus.b, 3);
        run_drv = 1'b0;
        step(1);
        chk("exec_not_aborted_pc", bus.pc, 2);
        run_drv = 1'b1;
        step(1);
        chk("sum_y_free", bus.en, 0);

        // NOP run with wrap; opcode D treated as NOP, flags held.
        clear_rom();
        rom[0] = 8'h10; rom[7] = 8'hD5;
        do_reset();
        step(2);
        chk("lit0_z", bus.z_flag, 1);
        step(13);
        chk("opd_en", bus.en, 0);
        chk("opd_b", bus.b, 0);
        step(1);
        chk("opd_z_held", bus.z_flag, 1);
        chk("opd_pc", bus.pc, 8);
        step(14);
        chk("pc_F", bus.pc, 15);
        step(2);
        chk("pc_wrap", bus.pc, 0);
        chk("wrap_z_held", bus.z_flag, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
